// File: rtl/types.sv
// Shared types for the iterative multiply/divide unit.
//   md_op_e    : RV32M operation select, encoded as funct3 (0-7).
//   md_state_e : md_unit control FSM states.
package types;

    typedef enum logic [2:0] {
        ENUM_MD_MUL    = 3'd0,
        ENUM_MD_MULH   = 3'd1,
        ENUM_MD_MULHSU = 3'd2,
        ENUM_MD_MULHU  = 3'd3,
        ENUM_MD_DIV    = 3'd4,
        ENUM_MD_DIVU   = 3'd5,
        ENUM_MD_REM    = 3'd6,
        ENUM_MD_REMU   = 3'd7
    } md_op_e;

    typedef enum logic [1:0] {
        StIdle,
        StCalc,
        StDone
    } md_state_e;

    // funct3[2] separates the divide group from the multiply group.
    function automatic logic op_is_div(md_op_e op);
        return op[2];
    endfunction

endpackage

// File: rtl/md_step.sv
// One iteration of the bit-serial multiply/divide datapath (purely combinational).
//   is_div   in  : 0 = shift-add multiply step, 1 = restoring divide step
//   hi, lo   in  : working register pair
//                  multiply: {partial product high, remaining multiplier bits}
//                  divide  : {partial remainder, remaining dividend / quotient bits}
//   opnd     in  : multiplicand (multiply) or divisor (divide) magnitude
//   hi_nxt, lo_nxt out : register pair after this step
module md_step #(
    parameter int unsigned XLEN = 32
) (
    input  logic            is_div,
    input  logic [XLEN-1:0] hi,
    input  logic [XLEN-1:0] lo,
    input  logic [XLEN-1:0] opnd,
    output logic [XLEN-1:0] hi_nxt,
    output logic [XLEN-1:0] lo_nxt
);

    logic [XLEN:0] sum;
    logic [XLEN:0] rem_shift;
    logic [XLEN:0] diff;

    always_comb begin
        // Multiply: add the multiplicand if the current multiplier bit is set,
        // then shift the whole {carry, hi, lo} right by one.
        sum = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : '0);

        // Divide: bring in the next dividend bit; the remainder stays below the
        // divisor, so the XLEN+1 bit difference sign is a reliable borrow flag.
        rem_shift = {hi, lo[XLEN-1]};
        diff      = rem_shift - {1'b0, opnd};

        if (is_div) begin
            if (!diff[XLEN]) begin
                hi_nxt = diff[XLEN-1:0];
                lo_nxt = {lo[XLEN-2:0], 1'b1};
            end else begin
                hi_nxt = rem_shift[XLEN-1:0];
                lo_nxt = {lo[XLEN-2:0], 1'b0};
            end
        end else begin
            hi_nxt = sum[XLEN:1];
            lo_nxt = {sum[0], lo[XLEN-1:1]};
        end
    end

endmodule

// File: rtl/md_unit.sv
// Iterative RV32M multiply/divide unit, one bit per cycle.
//   clk, rst_n  : clock (rising edge), asynchronous active-low reset
//   kill        : abandon any in-flight or pending operation
//   in_valid/in_ready, in_op, in_a, in_b : request handshake and operands
//   out_valid/out_ready, out_result      : result handshake and value
// Operands are converted to magnitudes on accept, processed unsigned for XLEN
// cycles, and sign-corrected on the final edge. Divide-by-zero and signed
// overflow finish straight from IDLE.
module md_unit
    import types::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            kill,
    input  logic            in_valid,
    output logic            in_ready,
    input  md_op_e          in_op,
    input  logic [XLEN-1:0] in_a,
    input  logic [XLEN-1:0] in_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_result
);

    localparam int unsigned   CntW    = $clog2(XLEN + 1);
    localparam logic [XLEN-1:0] MostNeg = {1'b1, {(XLEN-1){1'b0}}};

    md_state_e       state_q, state_d;
    md_op_e          op_q, op_d;
    logic            a_neg_q, a_neg_d;
    logic            b_neg_q, b_neg_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [XLEN-1:0] hi_q, hi_d;
    logic [XLEN-1:0] lo_q, lo_d;
    logic [XLEN-1:0] opnd_q, opnd_d;
    logic [XLEN-1:0] result_q, result_d;

    logic [XLEN-1:0] step_hi, step_lo;

    // Request decode
    logic            a_signed, b_signed, a_neg, b_neg, in_div, ovf;
    logic [XLEN-1:0] a_mag, b_mag;

    // Final-edge sign correction
    logic [2*XLEN-1:0] prod, prod_fix;
    logic [XLEN-1:0]   quot_fix, rem_fix;

    md_step #(
        .XLEN (XLEN)
    ) u_step (
        .is_div (op_is_div(op_q)),
        .hi     (hi_q),
        .lo     (lo_q),
        .opnd   (opnd_q),
        .hi_nxt (step_hi),
        .lo_nxt (step_lo)
    );

    assign in_ready   = (state_q == StIdle);
    assign out_valid  = (state_q == StDone);
    assign out_result = result_q;

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        a_neg_d  = a_neg_q;
        b_neg_d  = b_neg_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        opnd_d   = opnd_q;
        result_d = result_q;

        // MUL yields the same low half signed or unsigned, so it runs unsigned.
        a_signed = (in_op == ENUM_MD_MULH) || (in_op == ENUM_MD_MULHSU) ||
                   (in_op == ENUM_MD_DIV)  || (in_op == ENUM_MD_REM);
        b_signed = (in_op == ENUM_MD_MULH) || (in_op == ENUM_MD_DIV) ||
                   (in_op == ENUM_MD_REM);
        a_neg    = a_signed && in_a[XLEN-1];
        b_neg    = b_signed && in_b[XLEN-1];
        a_mag    = a_neg ? -in_a : in_a;
        b_mag    = b_neg ? -in_b : in_b;
        in_div   = op_is_div(in_op);
        ovf      = ((in_op == ENUM_MD_DIV) || (in_op == ENUM_MD_REM)) &&
                   (in_a == MostNeg) && (&in_b);

        prod     = {step_hi, step_lo};
        prod_fix = (a_neg_q ^ b_neg_q) ? -prod : prod;
        quot_fix = (a_neg_q ^ b_neg_q) ? -step_lo : step_lo;
        rem_fix  = a_neg_q ? -step_hi : step_hi;

        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    op_d    = in_op;
                    a_neg_d = a_neg;
                    b_neg_d = b_neg;
                    if (in_div && (in_b == '0)) begin
                        state_d  = StDone;
                        result_d = ((in_op == ENUM_MD_DIV) || (in_op == ENUM_MD_DIVU)) ?
                                   '1 : in_a;
                    end else if (ovf) begin
                        state_d  = StDone;
                        result_d = (in_op == ENUM_MD_DIV) ? MostNeg : '0;
                    end else begin
                        state_d = StCalc;
                        cnt_d   = CntW'(XLEN);
                        hi_d    = '0;
                        lo_d    = in_div ? a_mag : b_mag;
                        opnd_d  = in_div ? b_mag : a_mag;
                    end
                end
            end
            StCalc: begin
                hi_d  = step_hi;
                lo_d  = step_lo;
                cnt_d = cnt_q - CntW'(1);
                if (cnt_q == CntW'(1)) begin
                    state_d = StDone;
                    unique case (op_q)
                        ENUM_MD_MUL:                  result_d = prod_fix[XLEN-1:0];
                        ENUM_MD_MULH, ENUM_MD_MULHSU,
                        ENUM_MD_MULHU:                result_d = prod_fix[2*XLEN-1:XLEN];
                        ENUM_MD_DIV, ENUM_MD_DIVU:    result_d = quot_fix;
                        ENUM_MD_REM, ENUM_MD_REMU:    result_d = rem_fix;
                        default:                      result_d = result_q;
                    endcase
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // Kill wins over any accept or completion in the same cycle.
        if (kill) begin
            state_d = StIdle;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            op_q     <= ENUM_MD_MUL;
            a_neg_q  <= 1'b0;
            b_neg_q  <= 1'b0;
            cnt_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            opnd_q   <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            a_neg_q  <= a_neg_d;
            b_neg_q  <= b_neg_d;
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            opnd_q   <= opnd_d;
            result_q <= result_d;
        end
    end

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit (XLEN=32): directed RV32M cases, special
// cases, backpressure, kill and asynchronous reset, plus randomized operations
// checked against a 64-bit arithmetic reference model.
module tb_md_unit;
    import types::*;

    localparam int unsigned XLEN = 32;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        kill = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    md_op_e      in_op = ENUM_MD_MUL;
    logic [31:0] in_a = '0;
    logic [31:0] in_b = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_result;

    int checks = 0;
    int failures = 0;

    md_unit #(
        .XLEN (XLEN)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .kill       (kill),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_a       (in_a),
        .in_b       (in_b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Reference: RV32M semantics via 64-bit integer arithmetic.
    function automatic logic [31:0] ref_result(md_op_e op, logic [31:0] a, logic [31:0] b);
        longint          sa, sb, q;
        longint unsigned ua, ub;
        logic [63:0]     p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (op)
            ENUM_MD_MUL:    begin p = ua * ub;           return p[31:0];  end
            ENUM_MD_MULH:   begin p = sa * sb;           return p[63:32]; end
            ENUM_MD_MULHSU: begin p = sa * longint'(ub); return p[63:32]; end
            ENUM_MD_MULHU:  begin p = ua * ub;           return p[63:32]; end
            ENUM_MD_DIV: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                q = sa / sb;
                return q[31:0];
            end
            ENUM_MD_DIVU: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                p = ua / ub;
                return p[31:0];
            end
            ENUM_MD_REM: begin
                if (b == 32'd0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                q = sa % sb;
                return q[31:0];
            end
            default: begin
                if (b == 32'd0) return a;
                p = ua % ub;
                return p[31:0];
            end
        endcase
    endfunction

    // Cycles from the accepting cycle until out_valid is first seen high.
    function automatic int ref_latency(md_op_e op, logic [31:0] a, logic [31:0] b);
        if ((op inside {ENUM_MD_DIV, ENUM_MD_DIVU, ENUM_MD_REM, ENUM_MD_REMU}) && b == 32'd0)
            return 1;
        if ((op inside {ENUM_MD_DIV, ENUM_MD_REM}) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
            return 1;
        return XLEN + 1;
    endfunction

    task automatic run_op(input md_op_e op, input logic [31:0] a, input logic [31:0] b,
                          input int hold, input string tag);
        logic [31:0] exp;
        int          lat;
        exp = ref_result(op, a, b);
        @(negedge clk);
        in_valid = 1'b1;
        in_op    = op;
        in_a     = a;
        in_b     = b;
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        in_valid = 1'b0;
        in_a     = $urandom;
        in_b     = $urandom;
        while (!out_valid && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        check_eq({tag, " latency"}, 64'(lat), 64'(ref_latency(op, a, b)));
        check_eq({tag, " result"}, {32'd0, out_result}, {32'd0, exp});
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check_eq({tag, " hold"}, {30'd0, out_valid, in_ready, out_result},
                     {30'd0, 1'b1, 1'b0, exp});
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check_eq({tag, " back to idle"}, {62'd0, in_ready, out_valid}, 64'd2);
    endtask

    typedef struct {
        md_op_e      op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[12];
    logic [31:0] corner[5];

    initial begin
        int seen_valid;
        vecs[0]  = '{ENUM_MD_MUL,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB};
        vecs[1]  = '{ENUM_MD_MULH,   32'h8000_0000,  32'h8000_0000, 32'h4000_0000};
        vecs[2]  = '{ENUM_MD_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE};
        vecs[3]  = '{ENUM_MD_MULHSU, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF};
        vecs[4]  = '{ENUM_MD_DIV,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD};
        vecs[5]  = '{ENUM_MD_REM,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF};
        vecs[6]  = '{ENUM_MD_DIVU,   32'd100,        32'd7,         32'd14};
        vecs[7]  = '{ENUM_MD_REMU,   32'd100,        32'd7,         32'd2};
        vecs[8]  = '{ENUM_MD_DIV,    32'd5,          32'd0,         32'hFFFF_FFFF};
        vecs[9]  = '{ENUM_MD_REMU,   32'd5,          32'd0,         32'd5};
        vecs[10] = '{ENUM_MD_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000};
        vecs[11] = '{ENUM_MD_REM,    32'h8000_0000,  32'hFFFF_FFFF, 32'd0};
        corner   = '{32'd0, 32'd1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};

        repeat (2) @(negedge clk);
        check_eq("reset outputs", {30'd0, in_ready, out_valid, out_result}, {30'd0, 2'b10, 32'd0});
        rst_n = 1'b1;

        // Directed vectors: the table's expectations also cross-check the model.
        foreach (vecs[i]) begin
            check_eq($sformatf("model vec%0d", i), {32'd0, ref_result(vecs[i].op, vecs[i].a,
                     vecs[i].b)}, {32'd0, vecs[i].exp});
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, 0, $sformatf("vec%0d", i));
        end

        // Backpressure: result held and no new accept while out_ready is low.
        run_op(ENUM_MD_MULHU, 32'h1234_5678, 32'h9ABC_DEF0, 10, "backpressure");

        // Randomized operations with occasional corner operands.
        for (int n = 0; n < 60; n++) begin
            md_op_e      op;
            logic [31:0] a, b;
            op = md_op_e'(3'($urandom_range(0, 7)));
            a  = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : 32'($urandom);
            b  = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : 32'($urandom);
            run_op(op, a, b, $urandom_range(0, 2), $sformatf("rand%0d", n));
        end

        // Kill in IDLE blocks a simultaneous request.
        @(negedge clk);
        kill = 1'b1; in_valid = 1'b1; in_op = ENUM_MD_DIVU; in_a = 32'd100; in_b = 32'd7;
        @(negedge clk);
        kill = 1'b0; in_valid = 1'b0;
        check_eq("kill blocks accept", {62'd0, in_ready, out_valid}, 64'd2);

        // Kill 10 cycles into CALC.
        @(negedge clk);
        in_valid = 1'b1; in_op = ENUM_MD_DIVU; in_a = 32'd100; in_b = 32'd7;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (9) @(negedge clk);
        check_eq("busy before kill", {63'd0, in_ready}, 64'd0);
        kill = 1'b1;
        @(negedge clk);
        kill = 1'b0;
        check_eq("kill to idle", {62'd0, in_ready, out_valid}, 64'd2);
        seen_valid = 0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid) seen_valid++;
        end
        check_eq("no result after kill", 64'(seen_valid), 64'd0);
        run_op(ENUM_MD_DIVU, 32'd100, 32'd7, 0, "after kill");

        // Asynchronous reset mid-CALC, applied between clock edges.
        @(negedge clk);
        in_valid = 1'b1; in_op = ENUM_MD_MUL; in_a = 32'd7; in_b = 32'hFFFF_FFFD;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (9) @(negedge clk);
        check_eq("result before reset", {32'd0, out_result}, 64'd14);
        #2 rst_n = 1'b0;
        #1 check_eq("async reset", {30'd0, in_ready, out_valid, out_result},
                    {30'd0, 2'b10, 32'd0});
        @(negedge clk);
        rst_n = 1'b1;
        run_op(ENUM_MD_DIVU, 32'd100, 32'd7, 0, "after reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
